// File: rtl/turbo_enc_pkg.sv
// -----------------------------------------------------------------------------
// turbo_enc_pkg
// Shared definitions for the LTE turbo constituent (RSC) encoder:
//   - enc_state_t : encoder control FSM states
//   - G_FB, G_FF  : feedback / feed-forward generator polynomials, bit i is
//                   the coefficient of D^i (G_FB = 1+D^2+D^3, G_FF = 1+D+D^3)
//   - K_MAX       : largest information block length
//   - TAIL_LEN    : number of trellis termination steps
// -----------------------------------------------------------------------------
package turbo_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        TERM  = 2'd2,
        FLUSH = 2'd3
    } enc_state_t;

    localparam logic [3:0] G_FB     = 4'b1101;
    localparam logic [3:0] G_FF     = 4'b1011;
    localparam int         K_MAX    = 6144;
    localparam int         TAIL_LEN = 3;

endpackage

// File: rtl/rsc_trellis_step.sv
// -----------------------------------------------------------------------------
// rsc_trellis_step
// One combinational step of the 8-state RSC trellis.
//   u      : input bit (information bit, or tail bit during termination)
//   s      : current state, s[0]=s1, s[1]=s2, s[2]=s3
//   p      : parity bit  p = a ^ s1 ^ s3
//   s_next : next state  (s1,s2,s3) <= (a,s1,s2); the feedback bit
//            a = u ^ s2 ^ s3 is carried out as s_next[0]
// -----------------------------------------------------------------------------
module rsc_trellis_step
    import turbo_enc_pkg::*;
(
    input  logic       u,
    input  logic [2:0] s,
    output logic       p,
    output logic [2:0] s_next
);

    logic a;

    // Taps D^1..D^3 of each generator line up with s[0..2].
    assign a      = u ^ (^(s & G_FB[3:1]));
    assign p      = (a & G_FF[0]) ^ (^(s & G_FF[3:1]));
    assign s_next = {s[1:0], a};

endmodule

// File: rtl/turbo_rsc_encoder.sv
// -----------------------------------------------------------------------------
// turbo_rsc_encoder
// LTE turbo constituent encoder with a one-deep registered output stage.
// Optional feature macro: RSC_TERM_EN -- when defined, three tail steps drive
// the trellis back to 000 after the K information bits (K+3 outputs);
// otherwise the block ends after K outputs with the trellis unterminated.
// Ports:
//   clk, rst               : rising-edge clock, asynchronous active-high reset
//   start, blk_len         : begin a block of blk_len bits (sampled in IDLE)
//   din, din_valid         : information bit and qualifier
//   din_ready              : encoder accepts din this cycle
//   sys_out, par_out, last : systematic bit, parity bit, final-output flag
//   dout_valid, dout_ready : output handshake
//   busy                   : FSM is not IDLE
// -----------------------------------------------------------------------------
module turbo_rsc_encoder
    import turbo_enc_pkg::*;
#(
    parameter int LEN_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] blk_len,
    input  logic                 din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 sys_out,
    output logic                 par_out,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 last,
    output logic                 busy
);

    enc_state_t           state_q,      state_d;
    logic [2:0]           trellis_q,    trellis_d;
    logic [LEN_WIDTH-1:0] cnt_q,        cnt_d;
    logic [LEN_WIDTH-1:0] len_q,        len_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 sys_q,        sys_d;
    logic                 par_q,        par_d;
    logic                 last_q,       last_d;

    logic       out_free;
    logic       step_u;
    logic       step_p;
    logic [2:0] step_s_next;

    // The output register can take a new word if it is empty or being drained
    // this very cycle, so drain and refill happen back to back.
    assign out_free  = !dout_valid_q || dout_ready;
    assign din_ready = (state_q == ENC) && out_free;
    assign busy      = (state_q != IDLE);

    assign dout_valid = dout_valid_q;
    assign sys_out    = sys_q;
    assign par_out    = par_q;
    assign last       = last_q;

    // Single trellis step shared by data encoding and tail termination.
    rsc_trellis_step u_step (
        .u      (step_u),
        .s      (trellis_q),
        .p      (step_p),
        .s_next (step_s_next)
    );

    // Next-state logic
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:  if (start && (blk_len != '0)) state_d = ENC;
            ENC:   if (din_valid && din_ready && (cnt_q == len_q - 1'b1)) begin
`ifdef RSC_TERM_EN
                       state_d = TERM;
`else
                       state_d = FLUSH;
`endif
                   end
            TERM:  if (out_free && (cnt_q == LEN_WIDTH'(TAIL_LEN - 1))) state_d = FLUSH;
            FLUSH: if (out_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        trellis_d    = trellis_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        sys_d        = sys_q;
        par_d        = par_q;
        last_d       = last_q;
        step_u       = din;

        case (state_q)
            IDLE: begin
                if (start && (blk_len != '0)) begin
                    len_d     = blk_len;
                    trellis_d = '0;
                    cnt_d     = '0;
                end
            end
            ENC: begin
                if (din_valid && din_ready) begin
                    dout_valid_d = 1'b1;
                    sys_d        = din;
                    par_d        = step_p;
                    trellis_d    = step_s_next;
                    if (cnt_q == len_q - 1'b1) begin
                        // Counter is reused for the tail steps, so it never wraps.
                        cnt_d = '0;
`ifdef RSC_TERM_EN
                        last_d = 1'b0;
`else
                        last_d = 1'b1;
`endif
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        last_d = 1'b0;
                    end
                end
            end
            TERM: begin
                // Tail bit cancels the feedback (a = 0), shifting zeros in.
                step_u = trellis_q[1] ^ trellis_q[2];
                if (out_free) begin
                    dout_valid_d = 1'b1;
                    sys_d        = step_u;
                    par_d        = step_p;
                    trellis_d    = step_s_next;
                    last_d       = (cnt_q == LEN_WIDTH'(TAIL_LEN - 1));
                    cnt_d        = last_d ? '0 : cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            trellis_q    <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            dout_valid_q <= 1'b0;
            sys_q        <= 1'b0;
            par_q        <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            trellis_q    <= trellis_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            dout_valid_q <= dout_valid_d;
            sys_q        <= sys_d;
            par_q        <= par_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// -----------------------------------------------------------------------------
// tb_turbo_rsc_encoder
// Directed sequence with randomized data and handshakes for turbo_rsc_encoder.
// Reference model: feedback sequence a[n] = u[n]^a[n-2]^a[n-3], parity
// p[n] = a[n]^a[n-1]^a[n-3]; tail bits chosen so that a[n] = 0.
// -----------------------------------------------------------------------------
module tb_turbo_rsc_encoder;

    localparam int LW = 13;
`ifdef RSC_TERM_EN
    localparam int TAIL = 3;
`else
    localparam int TAIL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] blk_len;
    logic          din;
    logic          din_valid;
    logic          din_ready;
    logic          sys_out;
    logic          par_out;
    logic          dout_valid;
    logic          dout_ready;
    logic          last;
    logic          busy;

    turbo_rsc_encoder #(.LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .blk_len    (blk_len),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sys_out    (sys_out),
        .par_out    (par_out),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .last       (last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    bit   u_bits  [6144];
    bit   exp_sys [6147];
    bit   exp_par [6147];
    bit   got_par [6147];
    bit   a_hist  [6150];
    logic [2:0] model_state;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Builds expected sys/par streams and the final {s3,s2,s1} for k bits.
    function automatic void build_model(input int k);
        int tot;
        bit u;
        bit an;
        tot = k + TAIL;
        a_hist[0] = 0; a_hist[1] = 0; a_hist[2] = 0;
        for (int n = 0; n < tot; n++) begin
            if (n < k) begin
                u  = u_bits[n];
                an = u ^ a_hist[n+1] ^ a_hist[n];
            end else begin
                u  = a_hist[n+1] ^ a_hist[n];
                an = 1'b0;
            end
            a_hist[n+3] = an;
            exp_sys[n]  = u;
            exp_par[n]  = an ^ a_hist[n+2] ^ a_hist[n];
        end
        model_state = {a_hist[tot], a_hist[tot+1], a_hist[tot+2]};
    endfunction

    // Runs one block; abort_at >= 0 stops once that many bits were accepted.
    task automatic run_block(input int k, input bit rnd_ready, input bit poke, input int abort_at);
        int   total;
        int   in_idx;
        int   out_idx;
        int   cyc;
        bit   stalled;
        logic [3:0] held;
        total   = k + TAIL;
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        stalled = 0;
        held    = '0;
        build_model(k);
        @(negedge clk);
        blk_len = LW'(k); start = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check("busy_after_start", busy, 1);
        while (out_idx < total && cyc < 8 * total + 100) begin
            if (abort_at >= 0 && in_idx >= abort_at) return;
            din_valid  = (in_idx < k) ? ($urandom_range(3) != 0) : 1'b0;
            din        = 1'b0;
            if (in_idx < k) din = u_bits[in_idx];
            dout_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
            start      = 1'b0;
            if (poke && cyc == 5) begin start = 1'b1; blk_len = 7; end
            if (poke && cyc == 9) begin start = 1'b1; blk_len = 0; end
            #1;
            if (stalled) check("hold_while_stalled", {dout_valid, sys_out, par_out, last}, held);
            if (in_idx >= k) check("din_ready_after_k", din_ready, 0);
            if (dout_valid && dout_ready) begin
                check("sys_out", sys_out, exp_sys[out_idx]);
                check("par_out", par_out, exp_par[out_idx]);
                check("last", last, (out_idx == total - 1));
                got_par[out_idx] = par_out;
                out_idx++;
            end
            stalled = dout_valid && !dout_ready;
            held    = {dout_valid, sys_out, par_out, last};
            if (din_valid && din_ready) in_idx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        check("output_count", out_idx, total);
        for (int i = 0; i < 5 && busy; i++) @(negedge clk);
        #1;
        check("idle_after_block", {busy, dout_valid}, 2'b00);
        check("final_trellis", dut.trellis_q, model_state);
    endtask

    logic [7:0] imp_par;

    initial begin
        rst = 1'b1; start = 1'b0; blk_len = '0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {dout_valid, sys_out, par_out, last, din_ready, busy}, 6'b0);
        rst = 1'b0;

        // All-zero block.
        for (int i = 0; i < 6144; i++) u_bits[i] = 1'b0;
        run_block(40, 1'b0, 1'b0, -1);

        // Impulse response.
        u_bits[0] = 1'b1;
        run_block(40, 1'b0, 1'b0, -1);
        imp_par = 8'b11110010;
        for (int i = 0; i < 8; i++) check("impulse_par", got_par[i], imp_par[7-i]);
        check("impulse_final_state", dut.trellis_q, (TAIL != 0) ? 3'b000 : model_state);

        // Start with blk_len = 0 while idle is ignored.
        @(negedge clk); blk_len = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("zero_len_ignored", {busy, dout_valid}, 2'b00);

        // Start pulses while busy are ignored; block unaffected.
        for (int i = 0; i < 6144; i++) u_bits[i] = 1'($urandom_range(1));
        run_block(100, 1'b1, 1'b1, -1);

        // Long block with random backpressure.
        for (int i = 0; i < 6144; i++) u_bits[i] = 1'($urandom_range(1));
        run_block(6144, 1'b1, 1'b0, -1);

        // Mid-block reset, then a fresh block.
        run_block(40, 1'b0, 1'b0, 20);
        #2 rst = 1'b1;
        #1 check("midblock_reset_outputs", {dout_valid, sys_out, par_out, last, din_ready, busy}, 6'b0);
        @(negedge clk);
        check("reset_held_outputs", {dout_valid, sys_out, par_out, last, din_ready, busy}, 6'b0);
        rst = 1'b0; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("no_residual_after_reset", {busy, dout_valid}, 2'b00);
        for (int i = 0; i < 6144; i++) u_bits[i] = 1'($urandom_range(1));
        run_block(40, 1'b1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/turbo_rsc_encoder.md
TURBO_RSC_ENCODER -- requirements
Module: turbo_rsc_encoder

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 13, giving the block-length field width (K up to 6144).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a pulse that begins a block; it is sampled only in IDLE.
REQ-005 SHALL have port blk_len, input, LEN_WIDTH, the information length K; it is latched on an accepted start.
REQ-006 SHALL have ports din (input, 1) and din_valid (input, 1), the information bit and its qualifier.
REQ-007 SHALL have port din_ready, output, 1, which indicates the encoder accepts din this cycle.
REQ-008 SHALL have ports sys_out (output, 1) and par_out (output, 1), the systematic bit and the parity bit.
REQ-009 SHALL have port dout_valid, output, 1, which qualifies sys_out, par_out and last.
REQ-010 SHALL have port dout_ready, input, 1, the downstream acceptance signal.
REQ-011 SHALL have port last, output, 1, high on the final output of a block.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the LTE 8-state constituent code: feedback a=u^s2^s3, parity p=a^s1^s3, next state (s1,s2,s3)<=(a,s1,s2).
REQ-014 SHALL use the FSM states IDLE, ENC, TERM and FLUSH, with transitions as follows:
- IDLE->ENC on start with blk_len!=0.
- ENC->TERM after K accepted bits.
- TERM->FLUSH after 3 tail outputs.
- FLUSH->IDLE when the output register drains.
REQ-015 SHALL ignore start when it occurs with blk_len==0 or while busy.
REQ-016 SHALL clear the trellis state to 000 and the bit counter to 0 on an accepted start.
REQ-017 SHALL drive din_ready = (state==ENC) && (!dout_valid || dout_ready).
REQ-018 SHALL transfer input only when din_valid && din_ready.
REQ-019 SHALL register its output with 1-cycle latency: an input accepted in cycle n appears with dout_valid high in cycle n+1.
REQ-020 SHALL hold sys_out, par_out and last stable while dout_valid && !dout_ready.
REQ-021 SHALL, in TERM and when the output register is free, drive the tail input u=s2^s3 (forcing a=0), output sys_out=u and par_out=s1^s3, and step the state.
REQ-022 SHALL leave the state at 000 after the 3 tail steps.
REQ-023 SHALL assert last on the 3rd tail output, or on the Kth data output when termination is compiled out.
REQ-024 SHALL produce exactly K+3 outputs per block, or K outputs without termination.
REQ-025 SHALL count with a LEN_WIDTH-bit counter, compare against K-1 at accept, and never wrap within a block.
REQ-026 SHALL serve a simultaneous output drain and new input in the same cycle without a bubble.
REQ-027 SHALL NOT pause trellis stepping in TERM for din_valid; stepping is gated only by the output register.

Reset
REQ-028 SHALL, on rst, immediately force: state=IDLE, trellis=000, counter=0, dout_valid=0, sys_out=0, par_out=0, last=0, din_ready=0, busy=0.
REQ-029 SHALL abort a block in progress when rst is asserted mid-block, with no residual output after release.

Configuration
REQ-030 SHALL, with RSC_TERM_EN defined, perform the 3-step trellis termination of REQ-021.
REQ-031 SHALL, without RSC_TERM_EN, bypass TERM (ENC->FLUSH) and leave the trellis state unterminated.

Structure
REQ-032 SHALL place the FSM state typedef, the generator constants (G_FB=1+D^2+D^3, G_FF=1+D+D^3), K_MAX=6144 and TAIL_LEN=3 in the shared package turbo_enc_pkg.
REQ-033 SHALL implement the combinational step (u, s) -> (a, p, s_next) as the sub-module rsc_trellis_step.
REQ-034 SHALL instantiate rsc_trellis_step once and share it between the ENC and TERM states.

Verification
REQ-035 SHALL verify the all-zero block: K=40, din=0 -> 43 outputs, all sys/par 0, last on output 43.
REQ-036 SHALL verify the impulse response: K=40, din=1 then 0s -> first 8 par_out bits = 1,1,1,1,0,0,1,0, and a final state of 000 after the tail.
REQ-037 SHALL verify backpressure: dout_ready toggles 50% random on a K=6144 random block -> output matches the reference model bit-exact, with no stable-violation while stalled.
REQ-038 SHALL verify start rejection: start pulsed while busy, and start with blk_len=0 -> both ignored, and the block in progress is unaffected.
REQ-039 SHALL verify mid-block reset: rst at bit 20 of K=40, then a new K=40 block -> all outputs 0 during reset, and the new block is correct with state starting at 000.
REQ-040 SHALL verify the macro off: build without RSC_TERM_EN, K=40 -> exactly 40 outputs, last on the 40th, and no tail.
